// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/sub/accumulate unit.
// Holds the mode encodings and a small decode helper.
package adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  // ACC and CLR are the only modes that write the accumulator
  function automatic logic mode_writes_acc(
    input mode_e m
  );
    return m inside {MODE_ACC, MODE_CLR};
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One C-bit carry-chain slice of the pipelined adder.
// Pure combinational; the parent owns every pipeline register.
module adder_slice #(
  parameter int C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         ci,
  output logic [C-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [C:0] full;

  assign full = {1'b0, a}
              + {1'b0, b}
              + {{C{1'b0}}, ci};

  assign s  = full[C-1:0];
  assign co = full[C];

  // carry into the top bit, recovered from its sum bit
  assign c_msb_in = s[C-1] ^ a[C-1] ^ b[C-1];

endmodule

// File: rtl/adder_pipe_acc.sv
// Pipelined add/sub/accumulate unit with valid/ready on both sides.
// Carry chain is split into STAGES registered slices of WIDTH/STAGES bits.
module adder_pipe_acc
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [1:0]       In_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [WIDTH-1:0] Acc
);

  localparam int C = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) ||
      ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("adder_pipe_acc: bad WIDTH/STAGES");
  end

  typedef struct packed {
    logic             v;
    logic             wr_acc;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } beat_t;

  beat_t      beat_0;
  beat_t      st_in  [STAGES];
  beat_t      st_out [STAGES];
  logic       sl_co  [STAGES];
  logic       sl_cm  [STAGES];
  beat_t      last;
  logic       last_ovf;
  logic       stall;
  logic       acc_busy;
  mode_e      mode;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic [WIDTH-1:0] acc_q;

  assign mode  = mode_e'(In_mode);
  assign stall = out_valid_q && !Out_ready;

  always_comb begin
    acc_busy = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      acc_busy = acc_busy |
                 (st_in[k].v & st_in[k].wr_acc);
    end
  end

  assign In_ready = !stall &&
                    !((mode == MODE_ACC) && acc_busy);

  // operand/carry selection happens once, at accept
  always_comb begin
    beat_0        = '0;
    beat_0.v      = In_valid && In_ready;
    beat_0.wr_acc = mode_writes_acc(mode);
    beat_0.a      = A;
    unique case (mode)
      MODE_ADD: begin
        beat_0.b = B;
        beat_0.c = Cin;
      end
      MODE_SUB: begin
        beat_0.b = ~B;
        beat_0.c = 1'b1;
      end
      MODE_ACC: beat_0.b = acc_q;
      MODE_CLR: beat_0.a = '0;
      default:  beat_0.a = '0;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [C-1:0] sl_s;
    beat_t        nxt;

    if (k == 0) begin : g_head
      assign st_in[k] = beat_0;
    end else begin : g_reg
      beat_t beat_q;
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          beat_q <= '0;
        end else if (!stall) begin
          beat_q <= st_out[k-1];
        end
      end
      assign st_in[k] = beat_q;
    end

    adder_slice #(
      .C(C)
    ) u_slice (
      .a        (st_in[k].a[k*C +: C]),
      .b        (st_in[k].b[k*C +: C]),
      .ci       (st_in[k].c),
      .s        (sl_s),
      .co       (sl_co[k]),
      .c_msb_in (sl_cm[k])
    );

    always_comb begin
      nxt              = st_in[k];
      nxt.s[k*C +: C]  = sl_s;
      nxt.c            = sl_co[k];
    end

    assign st_out[k] = nxt;
  end

  assign last     = st_out[STAGES-1];
  assign last_ovf = sl_co[STAGES-1] ^ sl_cm[STAGES-1];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else if (!stall) begin
      out_valid_q <= last.v;
      if (last.v) begin
        sum_q  <= last.s;
        cout_q <= last.c;
        ovf_q  <= last_ovf;
        if (last.wr_acc) begin
          acc_q <= last.s;
        end
      end
    end
  end

  assign Out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign Acc       = acc_q;

endmodule
